// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI read-channel definitions: AR field widths, burst type codes,
// RRESP codes, slave FSM state type and the burst legality helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 2;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;

    localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
    localparam logic [BURST_W-1:0] BURST_RSVD  = 2'b11;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        RS_IDLE  = 1'b0,
        RS_BURST = 1'b1
    } rs_state_e;

    // A WRAP burst is only legal with 2/4/8/16 beats; the reserved burst
    // type is always illegal. Illegal bursts are carried out as INCR.
    function automatic logic burst_is_err(input logic [BURST_W-1:0] burst,
                                          input logic [LEN_W-1:0]   len);
        logic w_err;
        w_err = 1'b0;
        if (burst == BURST_RSVD) begin
            w_err = 1'b1;
        end else if (burst == BURST_WRAP) begin
            w_err = !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        end
        return w_err;
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_addr_gen
// Combinational next-beat address calculator for an AXI read burst.
// Ports:
//   i_addr      current beat byte address
//   i_size      log2 bytes per beat
//   i_len       beats-1 of the burst
//   i_burst     burst type (FIXED/INCR/WRAP/reserved)
//   o_next_addr byte address of the following beat (BusWidth-bit modular)
//   o_wrap_err  burst is illegal and is being treated as INCR
// ---------------------------------------------------------------------------
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int BusWidth = 32
) (
    input  logic [BusWidth-1:0] i_addr,
    input  logic [SIZE_W-1:0]   i_size,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [BURST_W-1:0]  i_burst,
    output logic [BusWidth-1:0] o_next_addr,
    output logic                o_wrap_err
);

    logic [BusWidth-1:0] w_inc;
    logic [BusWidth-1:0] w_span_mask;
    logic [BusWidth-1:0] w_incr_addr;

    always_comb begin
        w_inc       = BusWidth'(1) << i_size;
        // Wrap span is (len+1) beats of the beat size; mask selects the
        // offset inside that span.
        w_span_mask = ((BusWidth'(i_len) + BusWidth'(1)) << i_size) - BusWidth'(1);
        w_incr_addr = i_addr + w_inc;
        o_wrap_err  = burst_is_err(i_burst, i_len);
        o_next_addr = w_incr_addr;
        if (!o_wrap_err) begin
            if (i_burst == BURST_FIXED) begin
                o_next_addr = i_addr;
            end else if (i_burst == BURST_WRAP) begin
                o_next_addr = (i_addr & ~w_span_mask) | (w_incr_addr & w_span_mask);
            end
        end
    end

endmodule

// File: rtl/read_slave.sv
// ---------------------------------------------------------------------------
// read_slave
// AXI read-only slave backed by a MemDepth x BusWidth word memory with a
// backdoor preload port. One burst in flight; data is registered and valid
// the cycle after the address handshake.
// Ports:
//   ACLK, ARESET                     clock, synchronous active-high reset
//   ARID/ARADDR/ARLEN/ARSIZE/ARBURST read address channel fields
//   ARLOCK/ARCACHE/ARPROT            accepted and ignored
//   ARVALID/ARREADY                  address handshake
//   RID/RDATA/RRESP/RLAST            read data channel
//   RVALID/RREADY                    data handshake
//   mem_we/mem_waddr/mem_wdata       backdoor word write
//   o_state                          current FSM state (debug)
// Handshakes: a transfer happens at a rising edge where VALID and READY
// are both 1; VALID never depends on READY and the payload holds while
// VALID=1 and READY=0.
// ---------------------------------------------------------------------------
module read_slave
    import axi_pkg::*;
#(
    parameter int BusWidth = 32,
    parameter int tagbits  = 1,
    parameter int MemDepth = 64
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [tagbits-1:0]          ARID,
    input  logic [BusWidth-1:0]         ARADDR,
    input  logic [LEN_W-1:0]            ARLEN,
    input  logic [SIZE_W-1:0]           ARSIZE,
    input  logic [BURST_W-1:0]          ARBURST,
    input  logic [LOCK_W-1:0]           ARLOCK,
    input  logic [CACHE_W-1:0]          ARCACHE,
    input  logic [PROT_W-1:0]           ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [tagbits-1:0]          RID,
    output logic [BusWidth-1:0]         RDATA,
    output logic [RESP_W-1:0]           RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY,
    input  logic                        mem_we,
    input  logic [$clog2(MemDepth)-1:0] mem_waddr,
    input  logic [BusWidth-1:0]         mem_wdata,
    output rs_state_e                   o_state
);

    localparam int AW = $clog2(MemDepth);

    rs_state_e           r_state;
    rs_state_e           w_state_next;
    logic [BusWidth-1:0] r_mem [MemDepth];

    logic [tagbits-1:0]  r_id;
    logic [BusWidth-1:0] r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [SIZE_W-1:0]   r_size;
    logic [BURST_W-1:0]  r_burst;
    logic                r_err;
    logic [LEN_W-1:0]    r_cnt;
    logic [BusWidth-1:0] r_rdata;
    logic [RESP_W-1:0]   r_rresp;
    logic                r_rlast;

    logic                w_ar_hs;
    logic                w_beat;
    logic [BusWidth-1:0] w_next_addr;
    logic                w_gen_err;
    logic [BusWidth-1:0] w_load_addr;
    logic                w_load_err;
    logic                w_load_decerr;
    logic [BusWidth-1:0] w_load_data;
    logic [RESP_W-1:0]   w_load_resp;
    logic                w_load_last;
    logic                w_unused;

    assign w_unused = ^{ARLOCK, ARCACHE, ARPROT, w_gen_err};

    axi_addr_gen #(.BusWidth(BusWidth)) u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_wrap_err  (w_gen_err)
    );

    // FSM state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= RS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        ARREADY      = 1'b0;
        RVALID       = 1'b0;
        w_ar_hs      = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            RS_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    w_ar_hs      = 1'b1;
                    w_state_next = RS_BURST;
                end
            end
            RS_BURST: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    w_beat = 1'b1;
                    if (r_rlast) begin
                        w_state_next = RS_IDLE;
                    end
                end
            end
            default: w_state_next = RS_IDLE;
        endcase
    end

    // Payload for the beat being loaded: the first beat comes straight from
    // the AR channel, later beats from the address generator.
    always_comb begin
        w_load_addr   = w_ar_hs ? ARADDR : w_next_addr;
        w_load_err    = w_ar_hs ? burst_is_err(ARBURST, ARLEN) : r_err;
        w_load_decerr = |w_load_addr[BusWidth-1:AW+2];
        w_load_data   = r_mem[w_load_addr[AW+1:2]];
        w_load_resp   = w_load_err ? RESP_SLVERR : RESP_OKAY;
        if (w_load_decerr) begin
            w_load_data = '0;
            w_load_resp = RESP_DECERR;
        end
        w_load_last   = w_ar_hs ? (ARLEN == '0) : ((r_cnt + 4'd1) == r_len);
    end

    // Backdoor write; a read of the same word at this edge sees the old value.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_rresp <= '0;
            r_rlast <= 1'b0;
        end else if (w_ar_hs) begin
            r_id    <= ARID;
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_size  <= ARSIZE;
            r_burst <= ARBURST;
            r_err   <= w_load_err;
            r_cnt   <= '0;
            r_rdata <= w_load_data;
            r_rresp <= w_load_resp;
            r_rlast <= w_load_last;
        end else if (w_beat) begin
            if (r_rlast) begin
                r_rlast <= 1'b0;
            end else begin
                r_cnt   <= r_cnt + 4'd1;
                r_addr  <= w_next_addr;
                r_rdata <= w_load_data;
                r_rresp <= w_load_resp;
                r_rlast <= w_load_last;
            end
        end
    end

    assign RID     = r_id;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;
    assign o_state = r_state;

endmodule

// File: doc/read_slave.md
READ_SLAVE -- requirements
Module: read_slave

Interface
REQ-001 Parameter BusWidth, default 32, data and address width in bits.
REQ-002 Parameter tagbits, default 1, transaction ID width.
REQ-003 Parameter MemDepth, default 64, number of BusWidth-bit memory words; power of two.
REQ-004 ACLK  in  1  single clock; all state updates on the rising edge.
REQ-005 ARESET  in  1  reset; synchronous, active-high.
REQ-006 ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  tagbits/BusWidth/4/2/2  read address channel: ID, byte start address, beats-1, log2 bytes per beat, burst type.
REQ-007 ARLOCK/ARCACHE/ARPROT  in  2/4/3  accepted and ignored.
REQ-008 ARVALID in 1, ARREADY out 1  address handshake.
REQ-009 RID/RDATA/RRESP/RLAST  out  tagbits/BusWidth/2/1  read data channel.
REQ-010 RVALID out 1, RREADY in 1  data handshake.
REQ-011 mem_we/mem_waddr/mem_wdata  in  1/log2(MemDepth)/BusWidth  backdoor word preload port.

Function
REQ-012 Two states, IDLE and BURST; ARREADY is 1 exactly when state is IDLE.
REQ-013 IDLE: ARVALID=1 at an edge captures all AR fields, loads beat counter 0, and moves to BURST.
REQ-014 RVALID is 1 in the cycle directly after the AR handshake edge; no extra wait states.
REQ-015 BURST: RVALID is 1 continuously; RID = captured ARID.
REQ-016 While RVALID=1 and RREADY=0, RID, RDATA, RRESP, and RLAST hold stable.
REQ-017 Beat handshake (RVALID and RREADY at an edge): counter increments and the address advances; RDATA, RRESP, and RLAST are reloaded for the next beat.
REQ-018 RLAST is 1 exactly when counter equals captured ARLEN; beats per burst = ARLEN+1 (1..16).
REQ-019 Handshake on the RLAST beat returns to IDLE: RVALID=0 and ARREADY=1 in the next cycle.
REQ-020 RDATA is registered, word index = address[log2(MemDepth)+1:2]; narrow beats return the full word.
REQ-021 Address increment per beat = 1<<ARSIZE bytes, BusWidth-bit modular arithmetic.
REQ-022 FIXED (00): address does not change.
REQ-023 INCR (01): address += increment; word index wraps modulo MemDepth.
REQ-024 WRAP (10): wrap span = (ARLEN+1)<<ARSIZE bytes; next = (addr & ~(span-1)) | ((addr+inc) & (span-1)).
REQ-025 WRAP with ARLEN not in {1,3,7,15}, and burst type 11: behave as INCR with RRESP=10 (SLVERR) on every beat.
REQ-026 Byte address >= MemDepth*4: that beat has RRESP=11 (DECERR) and RDATA=0; otherwise RRESP=00.
REQ-027 mem_we writes mem_wdata at the edge; a simultaneous RDATA load of the same word returns the pre-write value.
REQ-028 ARVALID in BURST is ignored; no second transaction is queued.

Reset
REQ-029 ARESET=1 at an edge forces IDLE, ARREADY=1, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, and counter=0.
REQ-030 Reset mid-burst aborts it; there is no further beat for the aborted ID.
REQ-031 Memory contents are not cleared by reset.

Structure
REQ-032 Shared package axi_pkg holds burst encodings (FIXED/INCR/WRAP), RRESP codes (OKAY/SLVERR/DECERR), and AR field widths; ReadMaster and read_slave both use it.
REQ-033 Next-address calculation is a combinational sub-module axi_addr_gen (addr, size, len, burst -> next addr, wrap_err).

Verification
REQ-034 Preload mem[i]=i*0x11; AR ID=1 ADDR=0x08 LEN=3 SIZE=2 INCR, RREADY=1 -> 4 consecutive beats 0x22,0x33,0x44,0x55, RLAST on the 4th, RRESP=00, RID=1.
REQ-035 AR ADDR=0x0C LEN=3 SIZE=2 WRAP -> words 3,0,1,2 (addresses 0x0C,0x00,0x04,0x08).
REQ-036 AR LEN=2 SIZE=2 FIXED ADDR=0x10, RREADY toggling 1,0,0,1,1 -> 3 beats of 0x44; outputs stable while stalled; ARREADY=0 throughout.
REQ-037 AR ADDR=0xFC LEN=1 INCR with MemDepth=64 -> beat0 word 63 OKAY, beat1 address 0x100 RDATA=0 RRESP=11.
REQ-038 ARESET asserted after 2 beats of a LEN=7 burst -> next cycle RVALID=0, ARREADY=1; a new AR then completes normally.
REQ-039 Integration: ReadMaster FIFOs loaded with 2 entries each -> 4 bursts complete with alternating fifo order and matching RIDs.
